// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: pixel clock enable, H/V counters,
// and registered sync/de/RGB outputs for six selectable patterns.
module vga_pattern_gen #(
  parameter int COLOR_BITS = 6,
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int GRAD_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            mode,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic [11:0]           hcount,
  output logic [11:0]           vcount,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BOX_Y0  = V_ACTIVE / 2 - 16;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);
  localparam logic [COLOR_BITS-1:0] FULL = '1;

  logic [DIV_W-1:0]      r_div;
  logic [11:0]           r_h, r_v, r_box_x;
  logic [2:0]            r_mode_q;
  logic                  r_hsync, r_vsync, r_de, r_fs;
  logic [COLOR_BITS-1:0] r_red, r_green, r_blue;
  logic [11:0]           r_hcount, r_vcount;

  logic                  w_pix_ce, w_frame_first, w_active, w_hs_act, w_vs_act;
  logic [11:0]           w_box_next, w_box_cur;
  logic [2:0]            w_mode_cur, w_bar;
  logic                  w_in_box;
  logic [COLOR_BITS-1:0] w_r, w_g, w_b;

  assign w_pix_ce      = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_frame_first = (r_h == 12'd0) && (r_v == 12'd0);
  assign w_active      = (r_h < 12'(H_ACTIVE)) && (r_v < 12'(V_ACTIVE));
  assign w_hs_act      = (r_h >= 12'(H_ACTIVE + H_FP)) && (r_h < 12'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_act      = (r_v >= 12'(V_ACTIVE + V_FP)) && (r_v < 12'(V_ACTIVE + V_FP + V_SYNC));

  // Mode and box position take effect on pixel (0,0) itself, so bypass the registers there.
  assign w_box_next = ((13'(r_box_x) + 13'd36) > 13'(H_ACTIVE)) ? 12'd0 : r_box_x + 12'd4;
  assign w_box_cur  = w_frame_first ? w_box_next : r_box_x;
  assign w_mode_cur = w_frame_first ? mode : r_mode_q;
  assign w_in_box   = (r_h >= w_box_cur) && (r_h < w_box_cur + 12'd32) &&
                      (r_v >= 12'(BOX_Y0)) && (r_v < 12'(BOX_Y0 + 32));

  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_h >= 12'(k * BAR_W)) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_active) begin
      case (w_mode_cur)
        3'd0: begin
          w_r = {COLOR_BITS{~w_bar[1]}};
          w_g = {COLOR_BITS{~w_bar[2]}};
          w_b = {COLOR_BITS{~w_bar[0]}};
        end
        3'd1: begin
          if ((r_h[4:0] == 5'd0) || (r_v[4:0] == 5'd0) ||
              (r_h == 12'(H_ACTIVE - 1)) || (r_v == 12'(V_ACTIVE - 1))) begin
            w_r = FULL;
            w_g = FULL;
            w_b = FULL;
          end
        end
        3'd2: begin
          w_r = COLOR_BITS'(r_h >> GRAD_SHIFT);
          w_g = COLOR_BITS'(r_h >> GRAD_SHIFT);
          w_b = COLOR_BITS'(r_h >> GRAD_SHIFT);
        end
        3'd3: begin
          if (r_h[5] ^ r_v[5]) begin
            w_r = FULL;
            w_g = FULL;
            w_b = FULL;
          end
        end
        3'd4: begin
          w_r = FULL;
          w_g = FULL;
          w_b = FULL;
        end
        3'd5: begin
          w_b = FULL;
          if (w_in_box) begin
            w_r = FULL;
            w_g = FULL;
          end
        end
        default: begin
          w_r = '0;
          w_g = '0;
          w_b = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_pix_ce) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h      <= '0;
      r_v      <= '0;
      r_mode_q <= '0;
      r_box_x  <= '0;
    end else if (w_pix_ce) begin
      if (w_frame_first) begin
        r_mode_q <= mode;
        r_box_x  <= w_box_next;
      end
      if (r_h == 12'(H_TOTAL - 1)) begin
        r_h <= '0;
        r_v <= (r_v == 12'(V_TOTAL - 1)) ? 12'd0 : r_v + 12'd1;
      end else begin
        r_h <= r_h + 12'd1;
      end
    end
  end

  // Outputs reflect the pre-increment counters, one pixel behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync  <= ~HS_ON;
      r_vsync  <= ~VS_ON;
      r_de     <= 1'b0;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
      r_fs     <= 1'b0;
    end else begin
      r_fs <= w_pix_ce && w_frame_first;
      if (w_pix_ce) begin
        r_hsync  <= w_hs_act ? HS_ON : ~HS_ON;
        r_vsync  <= w_vs_act ? VS_ON : ~VS_ON;
        r_de     <= w_active;
        r_red    <= w_r;
        r_green  <= w_g;
        r_blue   <= w_b;
        r_hcount <= r_h;
        r_vcount <= r_v;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: every clk of a reduced-size mode is compared
// against a pixel-index reference model; a CLK_DIV=1 instance checks timing.
module tb_vga_pattern_gen;

  localparam int CB    = 6;
  localparam int DIV   = 2;
  localparam int HA    = 48, HFP = 2, HSW = 4, HBP = 2;
  localparam int VA    = 40, VFP = 1, VSW = 2, VBP = 2;
  localparam int GS    = 2;
  localparam int HT    = HA + HFP + HSW + HBP;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int FRAME_CLK = FRAME * DIV;
  localparam int LINE_CLK  = HT * DIV;
  localparam int LIM   = 2 * FRAME_CLK;
  localparam logic [CB-1:0] FULL = 6'h3f;
  localparam logic [45:0] RST_VEC = {3'b110, 43'd0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] mode = 3'd0;

  logic hsync, vsync, de, frame_start;
  logic [CB-1:0] red, green, blue;
  logic [11:0] hcount, vcount;
  logic d1_hsync, d1_vsync, d1_de, d1_frame_start;
  logic [CB-1:0] d1_red, d1_green, d1_blue;
  logic [11:0] d1_hcount, d1_vcount;
  logic [45:0] vec0, vec1;

  assign vec0 = {hsync, vsync, de, red, green, blue, hcount, vcount, frame_start};
  assign vec1 = {d1_hsync, d1_vsync, d1_de, d1_red, d1_green, d1_blue, d1_hcount, d1_vcount, d1_frame_start};

  vga_pattern_gen #(
    .COLOR_BITS(CB), .CLK_DIV(DIV),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .GRAD_SHIFT(GS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
  );

  vga_pattern_gen #(
    .COLOR_BITS(CB), .CLK_DIV(1),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .GRAD_SHIFT(GS)
  ) dut_div1 (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .hsync(d1_hsync), .vsync(d1_vsync), .de(d1_de),
    .red(d1_red), .green(d1_green), .blue(d1_blue),
    .hcount(d1_hcount), .vcount(d1_vcount), .frame_start(d1_frame_start)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: displayed pixel index since reset release
  function automatic logic [2:0] bar_color(int i);
    case (i)
      0: return 3'b111;  // white
      1: return 3'b110;  // yellow
      2: return 3'b011;  // cyan
      3: return 3'b010;  // green
      4: return 3'b101;  // magenta
      5: return 3'b100;  // red
      6: return 3'b001;  // blue
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [45:0] pixel(int n, logic [2:0] m, int bx, bit fs);
    int h, v;
    bit act, white, hs, vs;
    logic [2:0] c;
    logic [CB-1:0] r, g, b;
    h = n % HT;
    v = (n / HT) % VT;
    act = (h < HA) && (v < VA);
    white = 1'b0;
    r = '0; g = '0; b = '0;
    if (act) begin
      case (m)
        3'd0: begin
          c = bar_color(h / (HA / 8));
          r = c[2] ? FULL : '0;
          g = c[1] ? FULL : '0;
          b = c[0] ? FULL : '0;
        end
        3'd1: white = (h % 32 == 0) || (v % 32 == 0) || (h == HA - 1) || (v == VA - 1);
        3'd2: begin
          r = CB'((h / (1 << GS)) % (1 << CB));
          g = r;
          b = r;
        end
        3'd3: white = (((h / 32) + (v / 32)) % 2) == 1;
        3'd4: white = 1'b1;
        3'd5: begin
          white = (h >= bx) && (h < bx + 32) && (v >= VA / 2 - 16) && (v < VA / 2 + 16);
          b = FULL;
        end
        default: white = 1'b0;
      endcase
      if (white) begin
        r = FULL; g = FULL; b = FULL;
      end
    end
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    return {hs, vs, act, r, g, b, 12'(h), 12'(v), fs};
  endfunction

  int k = 0;
  int m_n = 0;
  int bx_frame = 0;
  logic [2:0] m_frame = 3'd0;
  logic [45:0] exp_v = RST_VEC;
  bit m_fs;
  bit chk_en = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k = 0;
      m_frame = 3'd0;
      bx_frame = 0;
      exp_v = RST_VEC;
    end else begin
      k++;
      if (k < DIV) begin
        exp_v = RST_VEC;
      end else begin
        m_n = k / DIV - 1;
        m_fs = (k % DIV == 0) && (m_n % FRAME == 0);
        if (m_fs) begin
          m_frame = mode;
          bx_frame = (bx_frame + 36 > HA) ? 0 : bx_frame + 4;
        end
        exp_v = pixel(m_n, m_frame, bx_frame, m_fs);
      end
    end
  end

  // scoreboard: every clk of the divided instance against the model
  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      check("pixel", {18'd0, vec0}, {18'd0, exp_v});
    end
  end

  // driver tasks
  task automatic release_reset();
    int t0 = 0;
    int t1 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk);
      #1;
      if (frame_start && t0 == 0) begin
        t0 = t;
        check("fs_pos", {40'd0, hcount, vcount}, 64'd0);
      end
      if (d1_frame_start && t1 == 0) t1 = t;
    end
    check("fs_latency", t0, DIV);
    check("fs_latency_div1", t1, 1);
  endtask

  task automatic wait_fs();
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!frame_start && t < FRAME_CLK + 10);
    check("fs_wait", frame_start, 1);
  endtask

  function automatic bit act_of(int sel);
    case (sel)
      0: return !hsync;
      1: return !d1_hsync;
      2: return de;
      default: return !vsync;
    endcase
  endfunction

  task automatic measure(input int sel, output int width, output int period, output int start_h);
    int t = 0;
    bit prev, cur;
    prev = act_of(sel);
    forever begin
      @(posedge clk);
      #1;
      cur = act_of(sel);
      t++;
      if ((cur && !prev) || t > LIM) break;
      prev = cur;
    end
    start_h = (sel == 1) ? int'(d1_hcount) : int'(hcount);
    width = 1;
    forever begin
      @(posedge clk);
      #1;
      if (!act_of(sel) || width > LIM) break;
      width++;
    end
    period = width + 1;
    forever begin
      @(posedge clk);
      #1;
      if (act_of(sel) || period > LIM) break;
      period++;
    end
  endtask

  int w, p, sh;

  initial begin
    reset_n = 1'b0;
    mode = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_dut", {18'd0, vec0}, {18'd0, RST_VEC});
    check("rst_div1", {18'd0, vec1}, {18'd0, RST_VEC});
    chk_en = 1'b1;
    release_reset();

    measure(0, w, p, sh);
    check("hs_width", w, HSW * DIV);
    check("hs_period", p, LINE_CLK);
    measure(1, w, p, sh);
    check("hs_width_div1", w, HSW);
    check("hs_period_div1", p, HT);
    measure(2, w, p, sh);
    check("de_width", w, HA * DIV);
    check("de_period", p, LINE_CLK);
    check("de_start_h", sh, 0);
    measure(3, w, p, sh);
    check("vs_width", w, VSW * LINE_CLK);
    check("vs_period", p, FRAME_CLK);

    // mode latch: switch mid-frame, takes effect next frame
    @(negedge clk);
    mode = 3'd0;
    wait_fs();
    wait_fs();
    check("bars_px0", {red, green, blue}, {3{FULL}});
    repeat (20 * LINE_CLK) @(negedge clk);
    mode = 3'd4;
    wait_fs();
    repeat (6 * DIV) @(posedge clk);
    #1;
    check("latch_white", {hcount, red, green, blue}, {12'd6, {3{FULL}}});

    // moving box across a wrap of box_x
    @(negedge clk);
    mode = 3'd5;
    repeat (7) begin
      wait_fs();
      check("box_bg", {red, green, blue}, {12'd0, FULL});
    end

    // random mode changes at random times
    repeat (4) begin
      repeat ($urandom_range(1, FRAME_CLK / 2)) @(negedge clk);
      mode = 3'($urandom_range(0, 7));
    end

    // asynchronous reset mid-frame
    repeat ($urandom_range(LINE_CLK, FRAME_CLK / 2)) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_async", {18'd0, vec0}, {18'd0, RST_VEC});
    check("rst_async_div1", {18'd0, vec1}, {18'd0, RST_VEC});
    repeat (3) @(negedge clk);
    mode = 3'($urandom_range(0, 7));
    release_reset();
    repeat (FRAME_CLK / 2) @(negedge clk);
    mode = 3'($urandom_range(0, 7));
    repeat (FRAME_CLK / 2 + 200) @(negedge clk);

    chk_en = 1'b0;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
